classifier_seq_ctrl: RTL and testbench

CLASSIFIER_SEQ_CTRL -- requirements
Module: classifier_seq_ctrl

---
 rtl/classifier_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_classifier_seq_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/classifier_seq_ctrl.sv
// Sequencer that loads features into a combinational classifier and captures its result.
// Optional cls_count output is compiled in when CLS_COUNT_EN is defined.
module classifier_seq_ctrl #(
    parameter int NUM_A         = 6,
    parameter int WIDTH_A       = 4,
    parameter int OUTWIDTH      = 19,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       feat_valid,
    output logic                       feat_ready,
    input  logic [WIDTH_A-1:0]         feat_data,
    output logic [NUM_A*WIDTH_A-1:0]   dp_inp,
    input  logic [OUTWIDTH-1:0]        dp_out,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [OUTWIDTH-1:0]        res_data,
    output logic                       busy
`ifdef CLS_COUNT_EN
    ,
    output logic [7:0]                 cls_count
`endif
);

    localparam int SW = (NUM_A > 1) ? $clog2(NUM_A) : 1;
    localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_A - 1);
    localparam logic [7:0] CNT_INIT = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOAD,
        SETTLE,
        RESULT
    } state_e;

    state_e                     state_q, state_d;
    logic [SW-1:0]              slot_q, slot_d;
    logic [7:0]                 cnt_q, cnt_d;
    logic [NUM_A*WIDTH_A-1:0]   inp_q, inp_d;
    logic [OUTWIDTH-1:0]        res_q, res_d;
    logic                       vld_q, vld_d;
`ifdef CLS_COUNT_EN
    logic [7:0]                 num_q, num_d;
`endif

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        cnt_d      = cnt_q;
        inp_d      = inp_q;
        res_d      = res_q;
        vld_d      = vld_q;
`ifdef CLS_COUNT_EN
        num_d      = num_q;
`endif
        feat_ready = (state_q == LOAD);
        busy       = (state_q != LOAD);

        unique case (state_q)
            LOAD: begin
                if (feat_valid) begin
                    for (int k = 0; k < NUM_A; k++) begin
                        if (slot_q == SW'(k)) begin
                            inp_d[k*WIDTH_A +: WIDTH_A] = feat_data;
                        end
                    end
                    if (slot_q == LAST_SLOT) begin
                        slot_d  = '0;
                        cnt_d   = CNT_INIT;
                        state_d = SETTLE;
                    end else begin
                        slot_d = slot_q + 1'b1;
                    end
                end
            end
            SETTLE: begin
                // Counter reaching zero marks the last settle edge: sample now.
                if (cnt_q == 8'd0) begin
                    res_d   = dp_out;
                    vld_d   = 1'b1;
                    state_d = RESULT;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    vld_d   = 1'b0;
                    state_d = LOAD;
`ifdef CLS_COUNT_EN
                    num_d   = num_q + 8'd1;
`endif
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            slot_q  <= '0;
            cnt_q   <= '0;
            inp_q   <= '0;
            res_q   <= '0;
            vld_q   <= 1'b0;
`ifdef CLS_COUNT_EN
            num_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            cnt_q   <= cnt_d;
            inp_q   <= inp_d;
            res_q   <= res_d;
            vld_q   <= vld_d;
`ifdef CLS_COUNT_EN
            num_q   <= num_d;
`endif
        end
    end

    assign dp_inp    = inp_q;
    assign res_data  = res_q;
    assign res_valid = vld_q;
`ifdef CLS_COUNT_EN
    assign cls_count = num_q;
`endif

endmodule

// File: tb/tb_classifier_seq_ctrl.sv
// Directed table-driven bench for classifier_seq_ctrl.
// Second instance covers the SETTLE_CYCLES=1 build.
module tb_classifier_seq_ctrl;

    localparam int ST = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        feat_valid;
    logic        feat_ready;
    logic [3:0]  feat_data;
    logic [23:0] dp_inp;
    logic [18:0] dp_out;
    logic        res_valid;
    logic        res_ready;
    logic [18:0] res_data;
    logic        busy;

    logic        f1_valid;
    logic        f1_ready;
    logic [3:0]  f1_data;
    logic [23:0] dp_inp1;
    logic [18:0] dp_out1;
    logic        res_valid1;
    logic        r1_ready;
    logic [18:0] res_data1;
    logic        busy1;
`ifdef CLS_COUNT_EN
    logic [7:0]  cls_count;
    logic [7:0]  cls_count1;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Stand-in for the combinational classifier.
    function automatic logic [18:0] model(input logic [23:0] v);
        return {v[23:12] ^ v[11:0], v[6:0]};
    endfunction

    assign dp_out  = model(dp_inp);
    assign dp_out1 = model(dp_inp1);

    classifier_seq_ctrl #(
        .NUM_A(6), .WIDTH_A(4), .OUTWIDTH(19), .SETTLE_CYCLES(ST)
    ) u_dut (
        .clk(clk), .rst(rst),
        .feat_valid(feat_valid), .feat_ready(feat_ready),
        .feat_data(feat_data), .dp_inp(dp_inp), .dp_out(dp_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .busy(busy)
`ifdef CLS_COUNT_EN
        , .cls_count(cls_count)
`endif
    );

    classifier_seq_ctrl #(
        .NUM_A(6), .WIDTH_A(4), .OUTWIDTH(19), .SETTLE_CYCLES(1)
    ) u_dut1 (
        .clk(clk), .rst(rst),
        .feat_valid(f1_valid), .feat_ready(f1_ready),
        .feat_data(f1_data), .dp_inp(dp_inp1), .dp_out(dp_out1),
        .res_valid(res_valid1), .res_ready(r1_ready),
        .res_data(res_data1), .busy(busy1)
`ifdef CLS_COUNT_EN
        , .cls_count(cls_count1)
`endif
    );

    typedef struct packed {
        logic [23:0] feats;
        logic [7:0]  gap;
        logic [23:0] exp_inp;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic feed(input logic [23:0] feats, input int gap);
        for (int k = 0; k < 6; k++) begin
            int n = 0;
            while (!feat_ready && n < 20) begin
                tick();
                n++;
            end
            if (n == 20) chk("feed_timeout", 32'(n), 32'd0);
            feat_valid = 1'b1;
            feat_data  = feats[23-4*k -: 4];
            tick();
            feat_valid = 1'b0;
            if (k < 5) repeat (gap) tick();
        end
    endtask

    task automatic wait_res(output int e);
        e = 0;
        while (!res_valid && e < 20) begin
            tick();
            e++;
        end
    endtask

    task automatic run_vec(input logic [23:0] feats, input int gap,
                           input logic [23:0] exp_inp);
        int e;
        logic stable;
        res_ready = 1'b1;
        feed(feats, gap);
        e = 0;
        stable = 1'b1;
        while (!res_valid && e < 20) begin
            if (dp_inp !== exp_inp) stable = 1'b0;
            tick();
            e++;
        end
        chk("latency", 32'(e), 32'(ST));
        chk("inp_stable", 32'(stable), 32'd1);
        chk("dp_inp", 32'(dp_inp), 32'(exp_inp));
        chk("res_data", 32'(res_data), 32'(model(exp_inp)));
        chk("busy_res", 32'(busy), 32'd1);
        chk("fr_res", 32'(feat_ready), 32'd0);
        tick();
        chk("hs_vld", 32'(res_valid), 32'd0);
        chk("hs_fr", 32'(feat_ready), 32'd1);
        chk("hs_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int e;
        logic seen;

        tbl[0] = '{24'h123456, 8'd0, 24'h654321};
        tbl[1] = '{24'h123456, 8'd3, 24'h654321};
        tbl[2] = '{24'hF0A5C3, 8'd0, 24'h3C5A0F};
        tbl[3] = '{24'h000000, 8'd1, 24'h000000};
        tbl[4] = '{24'hFFFFFF, 8'd0, 24'hFFFFFF};
        tbl[5] = '{24'h987654, 8'd2, 24'h456789};

        rst = 1'b1;
        feat_valid = 1'b0;
        feat_data = '0;
        res_ready = 1'b0;
        f1_valid = 1'b0;
        f1_data = '0;
        r1_ready = 1'b1;
        tick();
        tick();
        chk("rst_inp", 32'(dp_inp), 32'd0);
        chk("rst_vld", 32'(res_valid), 32'd0);
        chk("rst_data", 32'(res_data), 32'd0);
        chk("rst_fr", 32'(feat_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_vec(tbl[i].feats, int'(tbl[i].gap), tbl[i].exp_inp);
        end

        // Backpressure with stray feat_valid during RESULT.
        res_ready = 1'b0;
        feed(24'hABCDEF, 0);
        wait_res(e);
        chk("bp_lat", 32'(e), 32'(ST));
        feat_valid = 1'b1;
        feat_data = 4'h1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("bp_data", 32'(res_data), 32'(model(24'hFEDCBA)));
            chk("bp_vld", 32'(res_valid), 32'd1);
            chk("bp_fr", 32'(feat_ready), 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
        end
        feat_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        chk("bp_rel_fr", 32'(feat_ready), 32'd1);
        chk("bp_rel_vld", 32'(res_valid), 32'd0);
        chk("retain", 32'(dp_inp), 32'hFEDCBA);

        // Partial overwrite keeps upper slots from the previous vector.
        for (int k = 0; k < 2; k++) begin
            feat_valid = 1'b1;
            feat_data = 4'h0;
            tick();
        end
        feat_valid = 1'b0;
        chk("partial", 32'(dp_inp), 32'hFEDC00);

        // Reset mid-vector.
        pulse_rst();
        for (int k = 0; k < 3; k++) begin
            feat_valid = 1'b1;
            feat_data = 4'h7;
            tick();
        end
        feat_valid = 1'b0;
        pulse_rst();
        chk("mv_inp", 32'(dp_inp), 32'd0);
        chk("mv_vld", 32'(res_valid), 32'd0);
        chk("mv_fr", 32'(feat_ready), 32'd1);
        run_vec(24'h123456, 0, 24'h654321);

        // Reset during SETTLE: pending result is dropped.
        feed(24'h111111, 0);
        tick();
        pulse_rst();
        seen = 1'b0;
        for (int c = 0; c < ST + 4; c++) begin
            if (res_valid) seen = 1'b1;
            tick();
        end
        chk("st_spur", 32'(seen), 32'd0);
        chk("st_inp", 32'(dp_inp), 32'd0);
        chk("st_fr", 32'(feat_ready), 32'd1);

        // Reset during RESULT.
        res_ready = 1'b0;
        feed(24'h222222, 0);
        wait_res(e);
        chk("rs_lat", 32'(e), 32'(ST));
        pulse_rst();
        chk("rs_vld", 32'(res_valid), 32'd0);
        chk("rs_data", 32'(res_data), 32'd0);
        chk("rs_fr", 32'(feat_ready), 32'd1);
        res_ready = 1'b1;
        run_vec(24'hF0A5C3, 1, 24'h3C5A0F);

        // SETTLE_CYCLES=1 instance.
        for (int k = 0; k < 6; k++) begin
            f1_valid = 1'b1;
            f1_data = 4'(k + 8);
            tick();
        end
        f1_valid = 1'b0;
        e = 0;
        while (!res_valid1 && e < 20) begin
            tick();
            e++;
        end
        chk("s1_lat", 32'(e), 32'd1);
        chk("s1_inp", 32'(dp_inp1), 32'hDCBA98);
        chk("s1_data", 32'(res_data1), 32'(model(24'hDCBA98)));
        tick();
        chk("s1_fr", 32'(f1_ready), 32'd1);
        chk("s1_busy", 32'(busy1), 32'd0);

`ifdef CLS_COUNT_EN
        chk("s1_cnt", 32'(cls_count1), 32'd1);
        pulse_rst();
        chk("cnt_rst", 32'(cls_count), 32'd0);
        res_ready = 1'b1;
        for (int i = 1; i <= 257; i++) begin
            feed(24'h5A5A5A, 0);
            wait_res(e);
            if (e == 20) chk("cnt_to", 32'(e), 32'(ST));
            tick();
            if (i == 255) chk("cnt_255", 32'(cls_count), 32'd255);
            if (i == 256) chk("cnt_wrap", 32'(cls_count), 32'd0);
        end
        chk("cnt_257", 32'(cls_count), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
